// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store data memory.
package mem_pkg;

    // Access size encoding on req_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Top-level controller states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Request attributes carried alongside the registered read
    typedef struct packed {
        logic       fault;
        logic       write;
        logic       sgn;
        size_e      size;
        logic [1:0] lane;
    } rsp_ctl_t;

    // Word-index width for a given array depth
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module dmem_bank #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and read-before-write capture on the same edge
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_ls.sv
// Byte/half/word load-store data memory with fault detection and a clear sweep.
module data_memory_ls
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic                  init_done
);

    localparam int unsigned IW = idx_width(DEPTH);
    localparam int unsigned LO = IW + 2;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          run_q;
    logic          rsp_valid_q;
    rsp_ctl_t      pend_q;

    size_e         size;
    logic [1:0]    lane;
    logic          out_of_range;
    logic          fault_c;
    logic          accept;

    logic          bank_en;
    logic [3:0]    bank_be;
    logic [IW-1:0] bank_idx;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;

    assign size         = size_e'(req_size);
    assign lane         = req_addr[1:0];
    assign out_of_range = |(req_addr >> LO);
    assign accept       = req_valid && run_q;

    // Reject reserved sizes, misaligned accesses and addresses beyond the array
    always_comb begin
        fault_c = out_of_range;
        case (size)
            SZ_HALF: if (lane[0])       fault_c = 1'b1;
            SZ_WORD: if (lane != 2'b00) fault_c = 1'b1;
            SZ_RSVD:                    fault_c = 1'b1;
            default: ;
        endcase
    end

    // State, sweep counter and response bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= (state_d == ST_RUN);
            rsp_valid_q <= accept;
            if (accept) begin
                pend_q <= '{fault: fault_c, write: req_write, sgn: req_signed,
                            size: size, lane: lane};
            end
        end
    end

    // Next state plus bank port steering: sweep writes in CLEAR, requests in RUN
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_en    = 1'b0;
        bank_be    = 4'b0000;
        bank_idx   = req_addr[IW+1:2];
        bank_wdata = req_wdata;
        case (state_q)
            ST_CLEAR: begin
                bank_en    = 1'b1;
                bank_be    = 4'b1111;
                bank_idx   = cnt_q;
                bank_wdata = 32'h0;
                cnt_d      = cnt_q + IW'(1);
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (accept) begin
                    bank_en = 1'b1;
                    if (req_write && !fault_c) begin
                        case (size)
                            SZ_BYTE: begin
                                bank_be    = 4'b0001 << lane;
                                bank_wdata = {4{req_wdata[7:0]}};
                            end
                            SZ_HALF: begin
                                bank_be    = 4'b0011 << lane;
                                bank_wdata = {2{req_wdata[15:0]}};
                            end
                            default: bank_be = 4'b1111;
                        endcase
                    end
                end
            end
        endcase
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .be    (bank_be),
        .idx   (bank_idx),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Lane select and extension of the registered read word
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ext;
        b   = bank_rdata[{pend_q.lane, 3'b000} +: 8];
        h   = bank_rdata[{pend_q.lane[1], 4'b0000} +: 16];
        ext = 32'h0;
        case (pend_q.size)
            SZ_BYTE: ext = {{24{pend_q.sgn & b[7]}}, b};
            SZ_HALF: ext = {{16{pend_q.sgn & h[15]}}, h};
            SZ_WORD: ext = bank_rdata;
            default: ext = 32'h0;
        endcase
        rsp_rdata = (rsp_valid_q && !pend_q.fault && !pend_q.write) ? ext : 32'h0;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_valid_q & pend_q.fault;
    assign req_ready = run_q;
    assign init_done = run_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed, table-driven bench for data_memory_ls.
module tb_data_memory_ls;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_done;

    // Second instance: small array, no clear sweep, address width exactly fits
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic        b_write = 1'b0;
    logic [1:0]  b_size = 2'b10;
    logic        b_signed = 1'b0;
    logic [5:0]  b_addr = 6'h0;
    logic [31:0] b_wdata = 32'h0;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_fault;
    logic        b_init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_ls #(.DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .init_done(init_done)
    );

    data_memory_ls #(.DEPTH(16), .ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_size(b_size), .req_signed(b_signed),
        .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault), .init_done(b_init_done)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ef;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] er, input logic ef);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.er = er; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one request at posedge+1, return at posedge+1 after acceptance
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic [31:0] er, input logic ef);
        check({name, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({name, "_rdata"}, rsp_rdata, er);
        check({name, "_fault"}, {31'h0, rsp_fault}, {31'h0, ef});
    endtask

    // Count edges until init_done rises; bounded
    task automatic wait_init(output int n, output logic saw_rsp);
        n = 0;
        saw_rsp = 1'b0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) saw_rsp = 1'b1;
            if (n == 1) check("nc_ready_first_cycle", {31'h0, b_ready}, 32'h1);
            if (init_done) break;
        end
    endtask

    initial begin
        int   n;
        logic saw;

        vecs[0]  = mk(0, 2'b10, 0, 32'h3FC, 32'h0,        32'h00000000, 0);
        vecs[1]  = mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h00000000, 0);
        vecs[2]  = mk(0, 2'b00, 1, 32'h010, 32'h0,        32'hFFFFFFEF, 0);
        vecs[3]  = mk(0, 2'b00, 1, 32'h011, 32'h0,        32'hFFFFFFBE, 0);
        vecs[4]  = mk(0, 2'b00, 1, 32'h012, 32'h0,        32'hFFFFFFAD, 0);
        vecs[5]  = mk(0, 2'b00, 1, 32'h013, 32'h0,        32'hFFFFFFDE, 0);
        vecs[6]  = mk(0, 2'b00, 0, 32'h013, 32'h0,        32'h000000DE, 0);
        vecs[7]  = mk(1, 2'b10, 0, 32'h020, 32'hAAAAAAAA, 32'h00000000, 0);
        vecs[8]  = mk(1, 2'b01, 0, 32'h022, 32'h00001234, 32'h00000000, 0);
        vecs[9]  = mk(0, 2'b10, 0, 32'h020, 32'h0,        32'h1234AAAA, 0);
        vecs[10] = mk(0, 2'b01, 1, 32'h022, 32'h0,        32'h00001234, 0);
        vecs[11] = mk(0, 2'b01, 1, 32'h020, 32'h0,        32'hFFFFAAAA, 0);
        vecs[12] = mk(0, 2'b01, 0, 32'h012, 32'h0,        32'h0000DEAD, 0);
        vecs[13] = mk(0, 2'b10, 0, 32'h002, 32'h0,        32'h00000000, 1);
        vecs[14] = mk(1, 2'b01, 0, 32'h021, 32'h0000FFFF, 32'h00000000, 1);
        vecs[15] = mk(0, 2'b10, 0, 32'h020, 32'h0,        32'h1234AAAA, 0);
        vecs[16] = mk(0, 2'b11, 0, 32'h020, 32'h0,        32'h00000000, 1);
        vecs[17] = mk(0, 2'b10, 0, 32'h400, 32'h0,        32'h00000000, 1);
        vecs[18] = mk(1, 2'b00, 0, 32'h031, 32'h000000A5, 32'h00000000, 0);
        vecs[19] = mk(0, 2'b10, 0, 32'h030, 32'h0,        32'h0000A500, 0);
        vecs[20] = mk(0, 2'b00, 1, 32'h031, 32'h0,        32'hFFFFFFA5, 0);
        vecs[21] = mk(1, 2'b10, 0, 32'h80000000, 32'h77777777, 32'h00000000, 1);
        vecs[22] = mk(0, 2'b10, 0, 32'h000, 32'h0,        32'h00000000, 0);
        vecs[23] = mk(1, 2'b11, 0, 32'h010, 32'h11111111, 32'h00000000, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_nc_ready", {31'h0, b_ready}, 32'h0);
        rst_n = 1'b1;

        wait_init(n, saw);
        check("sweep_cycles", n, 256);
        check("sweep_no_rsp", {31'h0, saw}, 32'h0);
        check("ready_after_sweep", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd);
            check_rsp($sformatf("vec%0d", i), vecs[i].er, vecs[i].ef);
        end
        // Reserved-size store must not have touched 0x10
        issue(0, 2'b10, 0, 32'h010, 32'h0);
        check_rsp("rsvd_store_no_write", 32'hDEADBEEF, 0);
        @(posedge clk); #1;
        check("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("idle_rsp_rdata", rsp_rdata, 32'h0);

        // Back-to-back store then load
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h55;
        @(posedge clk); #1;
        check_rsp("b2b_store", 32'h0, 0);
        check("b2b_ready", {31'h0, req_ready}, 32'h1);
        req_write = 1'b0; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_rsp("b2b_load", 32'h00000055, 0);

        // No-clear instance: store and load back at its top word
        b_valid = 1'b1; b_write = 1'b1; b_size = 2'b10; b_addr = 6'h3C; b_wdata = 32'h0BADCAFE;
        @(posedge clk); #1;
        b_write = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("nc_load_valid", {31'h0, b_rsp_valid}, 32'h1);
        check("nc_load_rdata", b_rsp_rdata, 32'h0BADCAFE);

        // Reset while a load response is on the outputs
        issue(1, 2'b10, 0, 32'h050, 32'h12345678);
        issue(0, 2'b10, 0, 32'h050, 32'h0);
        check_rsp("pre_reset_load", 32'h12345678, 0);
        rst_n = 1'b0;
        #1;
        check("reset_drop_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_drop_rdata", rsp_rdata, 32'h0);
        check("reset_drop_ready", {31'h0, req_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        // A store held during the sweep must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h60;
        req_wdata = 32'hCAFEF00D;
        rst_n = 1'b1;
        wait_init(n, saw);
        req_valid = 1'b0;
        check("resweep_cycles", n, 256);
        check("resweep_no_rsp", {31'h0, saw}, 32'h0);

        issue(0, 2'b10, 0, 32'h050, 32'h0);
        check_rsp("cleared_0x50", 32'h0, 0);
        issue(0, 2'b10, 0, 32'h060, 32'h0);
        check_rsp("ignored_0x60", 32'h0, 0);
        issue(0, 2'b10, 0, 32'h010, 32'h0);
        check_rsp("cleared_0x10", 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
